// File: rtl/bt_sched_pkg.sv
// Shared encodings for the Bluetooth transmit scheduler: FSM states,
// grant codes and the burst header sync byte.
package bt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    HDR_WAIT = 3'd2,
    POP      = 3'd3,
    LOAD     = 3'd4,
    SEND     = 3'd5,
    WAIT     = 3'd6
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_SENS = 2'b01;
  localparam logic [1:0] GRANT_AT   = 2'b10;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  // Header word announcing a sensor burst of burst_len words.
  function automatic logic [15:0] hdr_word(input int burst_len);
    return {HDR_SYNC, 1'b0, 7'(burst_len)};
  endfunction

endpackage

// File: rtl/bt_sched_arbiter.sv
// Source eligibility and priority selection for the transmit scheduler.
// Holds last_grant so AT cannot starve the sensor stream.
module bt_sched_arbiter
  import bt_sched_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             arb_en,
  input  logic             link_up,
  input  logic             at_mode,
  input  logic             at_empty,
  input  logic [CNT_W-1:0] sens_count,
  output logic [1:0]       sel
);

  logic       at_elig;
  logic       sens_elig;
  logic [1:0] last_grant;

  always_comb begin
    at_elig   = at_mode && !at_empty;
    sens_elig = !at_mode && link_up && (sens_count >= CNT_W'(BURST_LEN));
    sel       = GRANT_NONE;
    if (arb_en) begin
      if (at_elig && sens_elig)
        sel = (last_grant == GRANT_AT) ? GRANT_SENS : GRANT_AT;
      else if (at_elig)
        sel = GRANT_AT;
      else if (sens_elig)
        sel = GRANT_SENS;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      last_grant <= GRANT_SENS;
    else if (sel != GRANT_NONE)
      last_grant <= sel;
  end

endmodule

// File: rtl/bt_tx_scheduler.sv
// Arbitrates the 16-bit serial transmitter between the sensor FIFO (framed
// bursts with a header) and the AT-command FIFO (raw words).
module bt_tx_scheduler
  import bt_sched_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int AT_MAX    = 32,
  parameter int CNT_W     = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             link_up,
  input  logic             at_mode,
  input  logic             sens_empty,
  input  logic [CNT_W-1:0] sens_count,
  input  logic [15:0]      sens_dout,
  output logic             sens_rd_en,
  input  logic             at_empty,
  input  logic [15:0]      at_dout,
  output logic             at_rd_en,
  output logic             tx_start,
  output logic [15:0]      tx_data,
  output logic             tx_more,
  input  logic             tx_done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [15:0]      pkt_count
);

  localparam logic [7:0]  SENS_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0]  AT_LAST   = 8'(AT_MAX - 1);
  localparam logic [15:0] HDR_WORD  = hdr_word(BURST_LEN);

  // Valid/ready-free handshake: tx_start is a one-cycle request, tx_done a
  // one-cycle completion; tx_data and tx_more hold from tx_start to tx_done.
  state_t     state;
  logic [7:0] word_cnt;
  logic       last_word;
  logic [1:0] sel;
  logic       is_sens;
  logic       pop_ok;
  logic       last_now;

  bt_sched_arbiter #(
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W)
  ) u_arbiter (
    .clock     (clock),
    .resetn    (resetn),
    .arb_en    (state == IDLE),
    .link_up   (link_up),
    .at_mode   (at_mode),
    .at_empty  (at_empty),
    .sens_count(sens_count),
    .sel       (sel)
  );

  always_comb begin
    is_sens  = (grant == GRANT_SENS);
    pop_ok   = is_sens ? !sens_empty : !at_empty;
    last_now = is_sens ? (word_cnt == SENS_LAST)
                       : ((word_cnt == AT_LAST) || at_empty);
  end

  // The FIFO pop must react to the empty flag in the same cycle.
  assign sens_rd_en = (state == POP) && (grant == GRANT_SENS) && !sens_empty;
  assign at_rd_en   = (state == POP) && (grant == GRANT_AT)   && !at_empty;

  // Pulse outputs are registered on entry so they are visible in HDR/SEND.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      word_cnt  <= 8'd0;
      last_word <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 16'h0000;
      tx_more   <= 1'b0;
      grant     <= GRANT_NONE;
      busy      <= 1'b0;
      pkt_count <= 16'h0000;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel != GRANT_NONE) begin
            grant    <= sel;
            busy     <= 1'b1;
            word_cnt <= 8'd0;
            if (sel == GRANT_SENS) begin
              tx_data  <= HDR_WORD;
              tx_start <= 1'b1;
              tx_more  <= 1'b1;
              state    <= HDR;
            end else begin
              state <= POP;
            end
          end
        end
        HDR:      state <= HDR_WAIT;
        HDR_WAIT: if (tx_done) state <= POP;
        POP:      if (pop_ok) state <= LOAD;
        LOAD: begin
          tx_data   <= is_sens ? sens_dout : at_dout;
          tx_start  <= 1'b1;
          tx_more   <= !last_now;
          last_word <= last_now;
          state     <= SEND;
        end
        SEND:     state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            word_cnt <= word_cnt + 8'd1;
            if (last_word) begin
              if (is_sens) pkt_count <= pkt_count + 16'd1;
              grant   <= GRANT_NONE;
              busy    <= 1'b0;
              tx_more <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= POP;
            end
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
